// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turn-gated two-digit number entry from decoded PS/2 key
// events, with Backspace/Esc editing, range check on Enter, idle timeout and
// a valid/ready handoff of the entered number to the game core.
module keypad_entry_ctrl #(
  parameter int MIN_VALUE      = 1,
  parameter int MAX_VALUE      = 25,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         turn_en,
  input  logic         num_ready,
  output logic [6:0]   num,
  output logic         num_valid,
  output logic         err,
  output logic [1:0]   entry_cnt,
  output logic [3:0]   entry_d1,
  output logic [3:0]   entry_d0
);

  // Idle counter only has to reach TIMEOUT_CYCLES-1.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] MIN_V = 7'(MIN_VALUE);
  localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_ISSUE    = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_DIGIT = 3'd1,
    KEY_ENTER = 3'd2,
    KEY_BKSP  = 3'd3,
    KEY_ESC   = 3'd4
  } key_kind_t;

  // Classify a {extend, scan code} into the key classes this block reacts to.
  function automatic key_kind_t key_kind(input logic [8:0] code);
    key_kind_t kind;
    case (code)
      9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
      9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046,
      9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
      9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D: kind = KEY_DIGIT;
      9'h05A, 9'h15A:                         kind = KEY_ENTER;
      9'h066:                                 kind = KEY_BKSP;
      9'h076:                                 kind = KEY_ESC;
      default:                                kind = KEY_NONE;
    endcase
    return kind;
  endfunction

  // Digit value for top-row and keypad digit codes; 0 for anything else.
  function automatic logic [3:0] key_digit(input logic [8:0] code);
    logic [3:0] dig;
    case (code)
      9'h045, 9'h070: dig = 4'd0;
      9'h016, 9'h069: dig = 4'd1;
      9'h01E, 9'h072: dig = 4'd2;
      9'h026, 9'h07A: dig = 4'd3;
      9'h025, 9'h06B: dig = 4'd4;
      9'h02E, 9'h073: dig = 4'd5;
      9'h036, 9'h074: dig = 4'd6;
      9'h03D, 9'h06C: dig = 4'd7;
      9'h03E, 9'h075: dig = 4'd8;
      9'h046, 9'h07D: dig = 4'd9;
      default:        dig = 4'd0;
    endcase
    return dig;
  endfunction

  state_t            state_r, state_next;
  logic [3:0]        d1_r, d1_next;
  logic [3:0]        d0_r, d0_next;
  logic [1:0]        cnt_r, cnt_next;
  logic [6:0]        num_r, num_next;
  logic              err_r, err_next;
  logic              num_valid_r;
  logic [IDLE_W-1:0] idle_r, idle_next;

  logic              press_s;
  key_kind_t         kind_s;
  logic [3:0]        digit_s;
  logic [3:0]        tens_s;
  logic [6:0]        value_s;
  logic              in_range_s;
  logic              idle_hit_s;

  // Key event decode and the value the held digits represent.
  always_comb begin
    press_s    = key_valid && key_down[last_change];
    kind_s     = key_kind(last_change);
    digit_s    = key_digit(last_change);
    if (cnt_r == 2'd2) begin
      tens_s = d1_r;
    end else begin
      tens_s = 4'd0;
    end
    value_s    = ({3'b000, tens_s} * 7'd10) + {3'b000, d0_r};
    in_range_s = (value_s >= MIN_V) && (value_s <= MAX_V);
    idle_hit_s = (idle_r == IDLE_LAST);
  end

  // Next-state, digit editing, range check and timeout.
  always_comb begin
    state_next = state_r;
    d1_next    = d1_r;
    d0_next    = d0_r;
    cnt_next   = cnt_r;
    num_next   = num_r;
    err_next   = 1'b0;
    idle_next  = {IDLE_W{1'b0}};

    case (state_r)
      ST_DISABLED: begin
        if (turn_en) begin
          state_next = ST_ENTRY;
        end else begin
          state_next = ST_DISABLED;
        end
      end

      ST_ENTRY: begin
        if (!turn_en) begin
          // Turn withdrawn: the clear wins over any key this cycle.
          state_next = ST_DISABLED;
          d1_next    = 4'd0;
          d0_next    = 4'd0;
          cnt_next   = 2'd0;
        end else if (press_s && (kind_s != KEY_NONE)) begin
          // Any decoded press restarts the idle count (idle_next default 0).
          case (kind_s)
            KEY_DIGIT: begin
              if (cnt_r == 2'd0) begin
                d0_next  = digit_s;
                cnt_next = 2'd1;
              end else if (cnt_r == 2'd1) begin
                d1_next  = d0_r;
                d0_next  = digit_s;
                cnt_next = 2'd2;
              end else begin
                err_next = 1'b1;
              end
            end
            KEY_BKSP: begin
              if (cnt_r == 2'd2) begin
                d0_next  = d1_r;
                d1_next  = 4'd0;
                cnt_next = 2'd1;
              end else if (cnt_r == 2'd1) begin
                d0_next  = 4'd0;
                d1_next  = 4'd0;
                cnt_next = 2'd0;
              end else begin
                cnt_next = 2'd0;
              end
            end
            KEY_ESC: begin
              d1_next  = 4'd0;
              d0_next  = 4'd0;
              cnt_next = 2'd0;
            end
            KEY_ENTER: begin
              if (cnt_r == 2'd0) begin
                state_next = ST_ENTRY;
              end else if (in_range_s) begin
                // Digits stay on display until the core takes the number.
                num_next   = value_s;
                state_next = ST_ISSUE;
              end else begin
                err_next = 1'b1;
                d1_next  = 4'd0;
                d0_next  = 4'd0;
                cnt_next = 2'd0;
              end
            end
            default: begin
              state_next = ST_ENTRY;
            end
          endcase
        end else if (cnt_r != 2'd0) begin
          if (idle_hit_s) begin
            d1_next  = 4'd0;
            d0_next  = 4'd0;
            cnt_next = 2'd0;
          end else begin
            idle_next = idle_r + 1'b1;
          end
        end else begin
          idle_next = {IDLE_W{1'b0}};
        end
      end

      ST_ISSUE: begin
        // A turn drop here does not withdraw the offer.
        if (num_ready) begin
          d1_next  = 4'd0;
          d0_next  = 4'd0;
          cnt_next = 2'd0;
          if (turn_en) begin
            state_next = ST_ENTRY;
          end else begin
            state_next = ST_DISABLED;
          end
        end else begin
          state_next = ST_ISSUE;
        end
      end

      default: begin
        state_next = ST_DISABLED;
        d1_next    = 4'd0;
        d0_next    = 4'd0;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // State and datapath registers; outputs come straight from these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_DISABLED;
      d1_r        <= 4'd0;
      d0_r        <= 4'd0;
      cnt_r       <= 2'd0;
      num_r       <= 7'd0;
      err_r       <= 1'b0;
      num_valid_r <= 1'b0;
      idle_r      <= {IDLE_W{1'b0}};
    end else begin
      state_r     <= state_next;
      d1_r        <= d1_next;
      d0_r        <= d0_next;
      cnt_r       <= cnt_next;
      num_r       <= num_next;
      err_r       <= err_next;
      num_valid_r <= (state_next == ST_ISSUE);
      idle_r      <= idle_next;
    end
  end

  assign num       = num_r;
  assign num_valid = num_valid_r;
  assign err       = err_r;
  assign entry_cnt = cnt_r;
  assign entry_d1  = d1_r;
  assign entry_d0  = d0_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with a scoreboard queue of expected
// transferred numbers, popped whenever the core-side handshake fires.
module tb_keypad_entry_ctrl;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         turn_en;
  logic         num_ready;
  logic [6:0]   num;
  logic         num_valid;
  logic         err;
  logic [1:0]   entry_cnt;
  logic [3:0]   entry_d1;
  logic [3:0]   entry_d0;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  keypad_entry_ctrl #(
    .MIN_VALUE(1),
    .MAX_VALUE(25),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .last_change(last_change),
    .key_down(key_down),
    .turn_en(turn_en),
    .num_ready(num_ready),
    .num(num),
    .num_valid(num_valid),
    .err(err),
    .entry_cnt(entry_cnt),
    .entry_d1(entry_d1),
    .entry_d0(entry_d0)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [8:0] code);
    key_valid         = 1'b1;
    last_change       = code;
    key_down          = '0;
    key_down[code]    = 1'b1;
    step();
    key_valid         = 1'b0;
    key_down          = '0;
  endtask

  task automatic release_key(input logic [8:0] code);
    key_valid   = 1'b1;
    last_change = code;
    key_down    = '0;
    step();
    key_valid   = 1'b0;
  endtask

  task automatic check_digits(input string tag, input logic [1:0] c,
                              input logic [3:0] t, input logic [3:0] o);
    check({tag, "_cnt"}, {30'd0, entry_cnt}, {30'd0, c});
    check({tag, "_d1"}, {28'd0, entry_d1}, {28'd0, t});
    check({tag, "_d0"}, {28'd0, entry_d0}, {28'd0, o});
  endtask

  // Scoreboard: every completed transfer must match the oldest expected number.
  always @(negedge clk) begin
    logic [6:0] exp_num;
    if (!rst && num_valid && num_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed=%0d expected=none", num);
      end else begin
        exp_num = exp_q.pop_front();
        check("sb_num", {25'd0, num}, {25'd0, exp_num});
      end
    end
  end

  initial begin
    rst         = 1'b1;
    key_valid   = 1'b0;
    last_change = 9'h000;
    key_down    = '0;
    turn_en     = 1'b0;
    num_ready   = 1'b0;
    step();
    step();
    check("rst_num_valid", {31'd0, num_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_num", {25'd0, num}, 32'd0);
    check_digits("rst", 2'd0, 4'd0, 4'd0);
    rst = 1'b0;
    step();

    // Turn not granted: presses do nothing.
    press(9'h016);
    check_digits("disabled", 2'd0, 4'd0, 4'd0);

    // Two-digit accept with core ready.
    turn_en   = 1'b1;
    num_ready = 1'b1;
    step();
    press(9'h016);
    check_digits("acc1", 2'd1, 4'd0, 4'd1);
    press(9'h01E);
    check_digits("acc2", 2'd2, 4'd1, 4'd2);
    exp_q.push_back(7'd12);
    press(9'h05A);
    check("acc_valid", {31'd0, num_valid}, 32'd1);
    check("acc_num", {25'd0, num}, 32'd12);
    step();
    check("acc_valid_one_cycle", {31'd0, num_valid}, 32'd0);
    check_digits("acc_clear", 2'd0, 4'd0, 4'd0);

    // Enter with nothing held: ignored, no error.
    press(9'h05A);
    check("enter_empty_err", {31'd0, err}, 32'd0);
    check("enter_empty_valid", {31'd0, num_valid}, 32'd0);

    // Releases never change state.
    press(9'h016);
    release_key(9'h016);
    check_digits("release", 2'd1, 4'd0, 4'd1);
    press(9'h076);
    check_digits("esc1", 2'd0, 4'd0, 4'd0);

    // Range reject: 30 via keypad and keypad Enter.
    press(9'h07A);
    press(9'h070);
    press(9'h15A);
    check("rej30_err", {31'd0, err}, 32'd1);
    check("rej30_valid", {31'd0, num_valid}, 32'd0);
    check_digits("rej30", 2'd0, 4'd0, 4'd0);
    step();
    check("rej30_err_pulse", {31'd0, err}, 32'd0);

    // Range reject: single 0 below MIN.
    press(9'h045);
    press(9'h05A);
    check("rej0_err", {31'd0, err}, 32'd1);
    check("rej0_valid", {31'd0, num_valid}, 32'd0);

    // Editing: 2, 4, Backspace, 5, Enter -> 25.
    press(9'h01E);
    press(9'h025);
    press(9'h066);
    check_digits("bksp", 2'd1, 4'd0, 4'd2);
    press(9'h02E);
    check_digits("edit25", 2'd2, 4'd2, 4'd5);
    exp_q.push_back(7'd25);
    press(9'h05A);
    check("edit_num", {25'd0, num}, 32'd25);
    check("edit_valid", {31'd0, num_valid}, 32'd1);
    step();

    // Third digit is rejected and leaves digits alone.
    press(9'h01E);
    press(9'h02E);
    press(9'h026);
    check("third_err", {31'd0, err}, 32'd1);
    check_digits("third", 2'd2, 4'd2, 4'd5);
    step();
    check("third_err_pulse", {31'd0, err}, 32'd0);
    press(9'h076);
    check_digits("esc2", 2'd0, 4'd0, 4'd0);

    // Handshake stall: 7 offered while core is not ready.
    num_ready = 1'b0;
    press(9'h03D);
    exp_q.push_back(7'd7);
    press(9'h05A);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        press(9'h016);
      end else begin
        step();
      end
      check("stall_valid", {31'd0, num_valid}, 32'd1);
      check("stall_num", {25'd0, num}, 32'd7);
      check("stall_cnt", {30'd0, entry_cnt}, 32'd1);
    end
    num_ready = 1'b1;
    step();
    check("stall_done_valid", {31'd0, num_valid}, 32'd0);
    check_digits("stall_done", 2'd0, 4'd0, 4'd0);
    num_ready = 1'b0;
    press(9'h025);
    check_digits("back_in_entry", 2'd1, 4'd0, 4'd4);

    // Turn drop with one digit held.
    turn_en = 1'b0;
    step();
    check_digits("turn_drop", 2'd0, 4'd0, 4'd0);
    press(9'h016);
    check_digits("turn_off_press", 2'd0, 4'd0, 4'd0);

    // Turn drop in the same cycle as a press: clear wins.
    turn_en = 1'b1;
    step();
    press(9'h016);
    turn_en = 1'b0;
    press(9'h01E);
    check_digits("drop_vs_press", 2'd0, 4'd0, 4'd0);

    // Timeout: 9 held, cleared after 16 idle cycles with no error.
    turn_en = 1'b1;
    step();
    press(9'h046);
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_err_quiet", {31'd0, err}, 32'd0);
    end
    check("to_not_yet", {30'd0, entry_cnt}, 32'd1);
    step();
    check_digits("to_clear", 2'd0, 4'd0, 4'd0);
    check("to_err", {31'd0, err}, 32'd0);

    // Timeout expiring on the same cycle as a press: press applies.
    press(9'h046);
    for (int i = 0; i < 15; i++) begin
      step();
    end
    press(9'h01E);
    check_digits("to_vs_press", 2'd2, 4'd9, 4'd2);
    press(9'h076);

    // Asynchronous reset while a number is offered.
    press(9'h02E);
    press(9'h05A);
    check("pre_rst_valid", {31'd0, num_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, num_valid}, 32'd0);
    check("arst_num", {25'd0, num}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check_digits("arst", 2'd0, 4'd0, 4'd0);
    step();
    rst = 1'b0;
    step();

    check("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Turn-gated number-entry controller between the PS/2 keyboard decoder and the Bingo game core. It consumes decoded key events (`key_valid`, `last_change`, `key_down`) and accumulates up to two decimal digits from the top row or keypad, supporting Backspace and Esc. On Enter it range-checks the value and hands it to the core over a valid/ready handshake. Partial entries are discarded after an idle timeout or when the core withdraws the turn.

## Interface
- `MIN_VALUE`, default 1: lowest accepted number.
- `MAX_VALUE`, default 25: highest accepted number; must be ≤ 99.
- `TIMEOUT_CYCLES`, default 500_000_000: idle cycles after which a partial entry is cleared. Minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: one-cycle key event strobe from the keyboard decoder.
- `last_change` in 9: {extend, scan code} of the event.
- `key_down` in 512: key state vector, already updated in the `key_valid` cycle.
- `turn_en` in 1: core permits entry (this player's turn).
- `num_ready` in 1: core accepts `num`.
- `num` out 7: entered value; meaningful only while `num_valid`.
- `num_valid` out 1: number offered to core.
- `err` out 1: one-cycle pulse on a rejected entry.
- `entry_cnt` out 2: digits held (0..2).
- `entry_d1`, `entry_d0` out 4 each: tens and ones digits held, for display.

## Operation
- **Press detection:** an event is a press iff `key_valid && key_down[last_change]`. Releases are ignored entirely.
- **Decode (9-bit `last_change`):**
  - Digits 0–9 top row: 045, 016, 01E, 026, 025, 02E, 036, 03D, 03E, 046.
  - Digits 0–9 keypad: 070, 069, 072, 07A, 06B, 073, 074, 06C, 075, 07D.
  - Enter: 05A or 15A. Backspace: 066. Esc: 076.
  - All other codes are ignored.
- **States:**
  - DISABLED: all keys ignored; go to ENTRY when `turn_en`=1.
  - ENTRY: handles keys as below; `turn_en`=0 clears digits and goes to DISABLED.
  - ISSUE: `num_valid`=1 and `num` is stable; keys are ignored. On `num_valid && num_ready`, clear digits and go to ENTRY if `turn_en`, else DISABLED. A drop of `turn_en` while in ISSUE does not withdraw the offer.
- **Key handling in ENTRY:**
  - Digit with `entry_cnt`=0: `d0`=digit, cnt=1.
  - Digit with cnt=1: `d1`=`d0`, `d0`=digit, cnt=2.
  - Digit with cnt=2: ignored, `err` pulse, digits unchanged.
  - Backspace: cnt=2 → `d0`=`d1`, `d1`=0, cnt=1. cnt=1 → cleared. cnt=0 → no effect.
  - Esc: clear all digits (cnt=0, `d1`=`d0`=0).
  - Enter with cnt=0: ignored, no `err`.
  - Enter with cnt>0: value = `d1`·10 + `d0`, with `d1`=0 when cnt=1, 7-bit unsigned.
    - If MIN ≤ value ≤ MAX: latch `num`=value and go to ISSUE.
    - Otherwise: `err` pulse, clear digits, stay in ENTRY.
- **Timeout:** idle counter resets on every decoded press in ENTRY and whenever cnt=0. It counts cycles while in ENTRY with cnt>0. When it reaches TIMEOUT_CYCLES−1, digits clear on the next edge; no `err`.

## Timing
- **Reset values:** state DISABLED, `num`=0, `num_valid`=0, `err`=0, `entry_cnt`=0, `entry_d1`=`entry_d0`=0, idle counter 0.
- **Key latency:** press in cycle t → digit, state, `num_valid`, and `err` updates visible at t+1.
- **Handshake:** `num_valid` rises at t+1 after Enter. If `num_ready`=1 in that same cycle, the transfer completes and `num_valid`=0 at t+2. `num` holds until the transfer completes.
- **Ready without valid:** `num_ready` while `num_valid`=0 has no effect.
- **Simultaneous events in ENTRY:**
  - `turn_en` falling in the same cycle as a press: the clear wins; the press is dropped.
  - Timeout expiry in the same cycle as a press: the press is applied and the counter resets.
- **`err` width:** exactly one cycle per rejected event.
- **Asynchronous reset:** at any point, including in ISSUE, it forces reset values immediately; an offered number is lost.

## Test plan
- **Two-digit accept:** `turn_en`=1; press 1 (016), 2 (01E), Enter (05A); `num_ready`=1 → `num`=12, `num_valid` high for exactly one cycle, `entry_cnt` returns to 0.
- **Range reject:**
  - Keypad 3 (07A), 0 (070), Enter (15A) → `err` pulse, no `num_valid`, cnt=0.
  - Single 0 then Enter → `err` (below MIN).
- **Editing:**
  - Press 2, 4, Backspace, 5, Enter → `num`=25.
  - A third digit after 2, 5 → `err` pulse, digits stay 2, 5.
  - Esc → cnt=0.
- **Handshake stall:**
  - Enter with value 7 and `num_ready`=0 for 10 cycles → `num_valid` held, `num`=7 stable, and digit presses during the stall are ignored.
  - `num_ready`=1 → transfer completes and state returns to ENTRY.
- **Turn and releases:**
  - `turn_en`=0 → presses have no effect.
  - Release events (`key_down` bit clear) never change state.
  - `turn_en` falling with cnt=1 → cnt=0 next cycle.
- **Timeout and reset:**
  - TIMEOUT_CYCLES=16; press 9 and idle 16 cycles → cnt=0, no `err`.
  - Assert `rst` while `num_valid`=1 → all outputs reach reset values immediately.
